pcc_sched: RTL and testbench



---
 rtl/pcc_sched.sv | 145 ++++++++++++++
 tb/tb_pcc_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcc_sched.sv
// pcc_sched: time-multiplexes one shared pcc (programmable classifier cell)
// across NUM_UNITS configured units for each accepted feature vector.
//
// A vector is accepted in IDLE. In EVAL one unit is evaluated per cycle:
// that unit's five select indices pick bits of the latched vector onto
// pcc_pos/pcc_neg, and the pcc's combinational answer is stored as result
// bit idx. After the last unit the collected vector is offered in DONE
// until the consumer takes it.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    feature vector handshake, in_feat = vector
//   out_valid/out_ready  result handshake, out_class = per-unit decisions
//   pcc_pos, pcc_neg     drive the shared pcc inputs
//   pcc_out              combinational decision from the shared pcc
//   cfg_we/addr/data     per-unit select word write (IDLE only)
//   busy                 high whenever the scheduler is not in IDLE

module pcc_sched #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned FEAT_W    = 8,
  localparam int unsigned SEL_W    = $clog2(FEAT_W),
  localparam int unsigned AW       = $clog2(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FEAT_W-1:0]    in_feat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_UNITS-1:0] out_class,
  output logic [1:0]           pcc_pos,
  output logic [2:0]           pcc_neg,
  input  logic                 pcc_out,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [5*SEL_W-1:0]   cfg_data,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e r_state, w_state_next;

  logic [FEAT_W-1:0]    r_feat;
  logic [AW-1:0]        r_idx;
  logic [NUM_UNITS-1:0] r_result;
  logic [NUM_UNITS-1:0] r_out_class;
  logic [5*SEL_W-1:0]   r_cfg [NUM_UNITS];

  logic [NUM_UNITS-1:0] w_result_next;
  logic [5*SEL_W-1:0]   w_cfg_cur;
  logic                 w_last;
  logic                 w_cfg_wr;
  logic                 w_accept;

  // Out-of-range selects read as 0 rather than aliasing onto a real bit.
  function automatic logic sel_bit(input logic [FEAT_W-1:0] feat,
                                   input logic [SEL_W-1:0]  sel);
    logic b;
    b = 1'b0;
    if (32'(sel) < FEAT_W) b = feat[sel];
    return b;
  endfunction

  assign w_cfg_cur = r_cfg[r_idx];
  assign w_last    = (r_idx == AW'(NUM_UNITS - 1));
  assign w_accept  = (r_state == StIdle) && in_valid;
  // Writes only land in IDLE so an in-flight vector never sees a mixed config.
  assign w_cfg_wr  = cfg_we && (r_state == StIdle) && (32'(cfg_addr) < NUM_UNITS);

  always_comb begin
    w_result_next        = r_result;
    w_result_next[r_idx] = pcc_out;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    pcc_pos      = '0;
    pcc_neg      = '0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = StEval;
      end
      StEval: begin
        pcc_pos[0] = sel_bit(r_feat, w_cfg_cur[0*SEL_W +: SEL_W]);
        pcc_pos[1] = sel_bit(r_feat, w_cfg_cur[1*SEL_W +: SEL_W]);
        pcc_neg[0] = sel_bit(r_feat, w_cfg_cur[2*SEL_W +: SEL_W]);
        pcc_neg[1] = sel_bit(r_feat, w_cfg_cur[3*SEL_W +: SEL_W]);
        pcc_neg[2] = sel_bit(r_feat, w_cfg_cur[4*SEL_W +: SEL_W]);
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: latched vector, unit index, working result and presented result.
  // out_class is a separate register so the previous answer stays visible
  // while the working result is cleared and refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat      <= '0;
      r_idx       <= '0;
      r_result    <= '0;
      r_out_class <= '0;
      for (int i = 0; i < int'(NUM_UNITS); i++) begin
        r_cfg[i] <= '0;
      end
    end else begin
      if (w_cfg_wr) r_cfg[cfg_addr] <= cfg_data;
      if (w_accept) begin
        r_feat   <= in_feat;
        r_idx    <= '0;
        r_result <= '0;
      end else if (r_state == StEval) begin
        r_result <= w_result_next;
        r_idx    <= r_idx + AW'(1);
        if (w_last) r_out_class <= w_result_next;
      end
    end
  end

  assign out_class = r_out_class;

endmodule

// File: tb/tb_pcc_sched.sv
module tb_pcc_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned FW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_feat;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_class;
  logic [1:0]    pcc_pos;
  logic [2:0]    pcc_neg;
  logic          pcc_out;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [5*SW-1:0] cfg_data;
  logic          busy;

  pcc_sched #(.NUM_UNITS(N), .FEAT_W(FW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_feat  (in_feat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .pcc_pos  (pcc_pos),
    .pcc_neg  (pcc_neg),
    .pcc_out  (pcc_out),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Shared pcc: positive bit 0 against the two low negative bits as a number.
  assign pcc_out = ({1'b0, pcc_pos[0]} >= pcc_neg[1:0]);

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [N-1:0] cls;
    int           acc;
  } exp_t;

  exp_t            q[$];
  logic [5*SW-1:0] m_cfg [N];
  logic [FW-1:0]   m_feat;
  bit              m_idle;
  int              m_left;
  bit              b2b = 1'b0;
  int              b2b_prev;

  function automatic logic pick(input logic [FW-1:0] feat, input int s);
    return (s < int'(FW)) ? feat[s] : 1'b0;
  endfunction

  function automatic int field(input int u, input int k);
    return int'(m_cfg[u][k*SW +: SW]);
  endfunction

  function automatic logic [4:0] unit_sel(input logic [FW-1:0] feat, input int u);
    logic [4:0] v;
    for (int k = 0; k < 5; k++) v[k] = pick(feat, field(u, k));
    return v;  // {neg2,neg1,neg0,pos1,pos0}
  endfunction

  function automatic logic [N-1:0] predict(input logic [FW-1:0] feat);
    logic [N-1:0] c;
    logic [4:0]   v;
    for (int u = 0; u < int'(N); u++) begin
      v    = unit_sel(feat, u);
      c[u] = (int'(v[0]) >= int'(v[3:2]));
    end
    return c;
  endfunction

  // Predictor: follows the handshake rules, checks control outputs, and
  // pushes the expected result of every accepted vector.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_idle   = 1'b1;
      m_left   = 0;
      m_feat   = '0;
      b2b_prev = -1;
      q.delete();
      for (int u = 0; u < int'(N); u++) m_cfg[u] = '0;
    end else begin
      logic [4:0] v;
      check(in_ready === m_idle, "in_ready", 32'(in_ready), 32'(m_idle));
      check(busy === !m_idle, "busy", 32'(busy), 32'(!m_idle));
      check(out_valid === (!m_idle && m_left == 0), "out_valid",
            32'(out_valid), 32'(!m_idle && m_left == 0));
      if (!m_idle && m_left > 0) begin
        v = unit_sel(m_feat, int'(N) - m_left);
        check(pcc_pos === v[1:0], "pcc_pos_eval", 32'(pcc_pos), 32'(v[1:0]));
        check(pcc_neg === v[4:2], "pcc_neg_eval", 32'(pcc_neg), 32'(v[4:2]));
      end else begin
        check(pcc_pos === 2'b00, "pcc_pos_idle", 32'(pcc_pos), 0);
        check(pcc_neg === 3'b000, "pcc_neg_idle", 32'(pcc_neg), 0);
      end
      if (!b2b) b2b_prev = -1;
      if (m_idle) begin
        if (cfg_we && int'(cfg_addr) < int'(N)) m_cfg[cfg_addr] = cfg_data;
        if (in_valid) begin
          exp_t e;
          m_feat = in_feat;
          e.cls  = predict(in_feat);
          e.acc  = cyc + 1;
          q.push_back(e);
          if (b2b && b2b_prev >= 0)
            check((e.acc - b2b_prev) == int'(N) + 2, "b2b_spacing",
                  32'(e.acc - b2b_prev), N + 2);
          b2b_prev = e.acc;
          m_idle   = 1'b0;
          m_left   = int'(N);
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (out_ready) begin
        m_idle = 1'b1;
      end
    end
  end

  // Monitor: compares every presented result against the scoreboard.
  bit seen_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_valid = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check(1'b0, "spurious_out_valid", 32'(out_class), 0);
      end else begin
        if (!seen_valid) begin
          check(cyc == q[0].acc + int'(N), "latency", 32'(cyc - q[0].acc), N);
          seen_valid = 1'b1;
        end
        check(out_class === q[0].cls, "out_class", 32'(out_class), 32'(q[0].cls));
        if (out_ready) begin
          void'(q.pop_front());
          seen_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f);
    in_valid = 1'b1;
    in_feat  = f;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    check(out_class === '0, "reset_out_class", 32'(out_class), 0);
    check(in_ready === 1'b1, "reset_in_ready", 32'(in_ready), 1);
    tick();

    // All-zero config: every select is bit 0.
    send(8'h01);
    tick(N + 3);

    // Unit 0: pos0=0 pos1=1 neg0=2 neg1=3 neg2=4.
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    tick();
    cfg_we = 1'b0;
    send(8'h01);
    tick(N + 3);

    // Consumer stalls for 5 cycles in DONE.
    out_ready = 1'b0;
    send(8'h0D);
    tick(N + 5);
    out_ready = 1'b1;
    tick(3);

    // Config write during EVAL must be ignored.
    send(8'h01);
    tick(1);
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = '0;
    tick();
    cfg_we = 1'b0;
    tick(N + 2);
    send(8'h01);
    tick(N + 3);

    // Config write and vector together in IDLE.
    cfg_we   = 1'b1;
    cfg_addr = 2'd2;
    cfg_data = {3'd7, 3'd6, 3'd5, 3'd1, 3'd1};
    send(8'h02);
    cfg_we = 1'b0;
    tick(N + 3);

    // Reset two cycles into EVAL aborts the vector and clears config.
    send(8'h01);
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    check(out_class === '0, "abort_out_class", 32'(out_class), 0);
    tick();
    send(8'h01);
    tick(N + 3);

    // Reprogram with random configs, then back-to-back vectors.
    for (int u = 0; u < int'(N); u++) begin
      cfg_we   = 1'b1;
      cfg_addr = AW'(u);
      cfg_data = 15'($urandom);
      tick();
    end
    cfg_we   = 1'b0;
    b2b      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6 * int'(N + 2); i++) begin
      in_feat = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    b2b      = 1'b0;
    tick(N + 3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 2) == 0;
      in_feat   = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      cfg_we    = ($urandom % 6) == 0;
      cfg_addr  = AW'($urandom);
      cfg_data  = 15'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    tick(2 * N + 6);
    check(q.size() == 0, "drain", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
